// File: rtl/snn_decay_pkg.sv
// Shared definitions for the potential decay unit: FP32 field layout,
// decay-rate codes, sweep FSM states and the same-sign FP32 adder used
// by the optional x0.75 mode (DECAY_THREEQ_EN).
package snn_decay_pkg;

    localparam int unsigned FP_W        = 32;
    localparam int unsigned FP_SIGN_BIT = 31;
    localparam int unsigned FP_EXP_MSB  = 30;
    localparam int unsigned FP_EXP_LSB  = 23;
    localparam int unsigned FP_EXP_W    = 8;
    localparam int unsigned FP_MAN_W    = 23;

    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = '1;

    localparam logic [3:0] RATE_X1     = 4'b0001;
    localparam logic [3:0] RATE_DIV2   = 4'b0010;
    localparam logic [3:0] RATE_DIV4   = 4'b0100;
    localparam logic [3:0] RATE_DIV8   = 4'b1000;
    localparam logic [3:0] RATE_THREEQ = 4'b0011;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCalc,
        StEmit,
        StDone
    } decay_state_e;

    // Adds two FP32 values of equal sign where a's exponent >= b's exponent.
    // An underflowed (zero) b leaves a unchanged. Result is truncated.
    function automatic logic [FP_W-1:0] fp_add_same_sign(input logic [FP_W-1:0] a,
                                                         input logic [FP_W-1:0] b);
        logic [FP_EXP_W-1:0] ea;
        logic [FP_EXP_W-1:0] eb;
        logic [FP_EXP_W-1:0] diff;
        logic [FP_MAN_W+1:0] ma;
        logic [FP_MAN_W+1:0] mb;
        logic [FP_MAN_W+1:0] sum;
        logic [FP_W-1:0]     res;
        ea = a[FP_EXP_MSB:FP_EXP_LSB];
        eb = b[FP_EXP_MSB:FP_EXP_LSB];
        if (eb == '0) begin
            res = a;
        end else begin
            diff = ea - eb;
            ma   = {2'b01, a[FP_MAN_W-1:0]};
            mb   = {2'b01, b[FP_MAN_W-1:0]} >> diff;
            sum  = ma + mb;
            // A carry out of the hidden bit renormalises by one position.
            if (sum[FP_MAN_W+1]) begin
                res = {a[FP_SIGN_BIT], ea + 8'd1, sum[FP_MAN_W:1]};
            end else begin
                res = {a[FP_SIGN_BIT], ea, sum[FP_MAN_W-1:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/potential_decay_unit_if.sv
// Handshake bundle of the potential decay unit.
//   cfg_*  : configuration writes (potential + rate code)
//   upd_*  : potential updates from the potential adder
//   start  : timestep pulse; busy/done report sweep progress
//   out_*  : decayed potential stream with valid/ready handshake
// master drives requests (testbench / controller); slave is the decay unit.
interface potential_decay_unit_if #(
    parameter int unsigned ADDR_W = 5
) ();

    logic              cfg_valid;
    logic [ADDR_W-1:0] cfg_addr;
    logic [31:0]       cfg_potential;
    logic [3:0]        cfg_rate;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_addr;
    logic [31:0]       upd_potential;
    logic              start;
    logic              out_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_potential;
    logic              busy;
    logic              done;

    modport master (
        output cfg_valid, cfg_addr, cfg_potential, cfg_rate,
        output upd_valid, upd_addr, upd_potential,
        output start, out_ready,
        input  out_valid, out_addr, out_potential, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_addr, cfg_potential, cfg_rate,
        input  upd_valid, upd_addr, upd_potential,
        input  start, out_ready,
        output out_valid, out_addr, out_potential, busy, done
    );

endinterface

// File: rtl/potential_decay_shift.sv
// Divides an FP32 value by 2^k by lowering its exponent.
//   x : FP32 input
//   k : shift amount 0..3 (0 passes x through)
//   y : result; signed zero when the exponent would reach or pass 0
// Zero/denormal (exp 0) and Inf/NaN (exp 255) pass through unchanged.
module potential_decay_shift
    import snn_decay_pkg::*;
(
    input  logic [FP_W-1:0] x,
    input  logic [1:0]      k,
    output logic [FP_W-1:0] y
);

    logic [FP_EXP_W-1:0] exp_in;
    logic [FP_EXP_W-1:0] k_ext;

    assign exp_in = x[FP_EXP_MSB:FP_EXP_LSB];
    assign k_ext  = FP_EXP_W'(k);

    always_comb begin
        y = x;
        if (k != 2'd0 && exp_in != '0 && exp_in != FP_EXP_MAX) begin
            if (exp_in <= k_ext) begin
                y = {x[FP_SIGN_BIT], {(FP_W-1){1'b0}}};
            end else begin
                y = {x[FP_SIGN_BIT], exp_in - k_ext, x[FP_MAN_W-1:0]};
            end
        end
    end

endmodule

// File: rtl/potential_decay_unit.sv
// Holds NUM_NEURONS FP32 membrane potentials with per-neuron rate codes and,
// on each start pulse, sweeps them in address order: load, decay, emit over
// out_* (valid/ready), and write the decayed value back on the handshake.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : potential_decay_unit_if slave (cfg, upd, start, out, busy, done)
// Optional: define DECAY_THREEQ_EN to enable rate code 0011 (x0.75).
module potential_decay_unit
    import snn_decay_pkg::*;
#(
    parameter int unsigned NUM_NEURONS    = 32,
    parameter int unsigned ADDR_W         = $clog2(NUM_NEURONS),
    parameter logic [31:0] INIT_POTENTIAL = 32'h41DED852
) (
    input  logic                    CLK,
    input  logic                    RST,
    potential_decay_unit_if.slave   bus
);

    decay_state_e      state_q;
    decay_state_e      state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [FP_W-1:0]   pot_q [NUM_NEURONS];
    logic [3:0]        rate_q [NUM_NEURONS];
    logic [FP_W-1:0]   cur_pot_q;
    logic [3:0]        cur_rate_q;
    logic [FP_W-1:0]   result_q;
    logic [FP_W-1:0]   decayed;
    logic [FP_W-1:0]   shift_a;
    logic [1:0]        shift_k;
    logic              last_addr;
    logic              emit_fire;

    assign last_addr = (addr_q == ADDR_W'(NUM_NEURONS - 1));
    assign emit_fire = (state_q == StEmit) && bus.out_ready;

    always_comb begin
        unique case (cur_rate_q)
            RATE_DIV2:   shift_k = 2'd1;
            RATE_DIV4:   shift_k = 2'd2;
            RATE_DIV8:   shift_k = 2'd3;
`ifdef DECAY_THREEQ_EN
            RATE_THREEQ: shift_k = 2'd1;
`else
            RATE_THREEQ: shift_k = 2'd0;
`endif
            default:     shift_k = 2'd0;
        endcase
    end

    potential_decay_shift u_shift_a (
        .x (cur_pot_q),
        .k (shift_k),
        .y (shift_a)
    );

`ifdef DECAY_THREEQ_EN
    logic [FP_W-1:0]     shift_b;
    logic [FP_EXP_W-1:0] cur_exp;

    assign cur_exp = cur_pot_q[FP_EXP_MSB:FP_EXP_LSB];

    potential_decay_shift u_shift_b (
        .x (cur_pot_q),
        .k (2'd2),
        .y (shift_b)
    );

    always_comb begin
        decayed = shift_a;
        if (cur_rate_q == RATE_THREEQ) begin
            // Special encodings must not be fed through the x/2 + x/4 sum.
            if (cur_exp == '0 || cur_exp == FP_EXP_MAX) begin
                decayed = cur_pot_q;
            end else begin
                decayed = fp_add_same_sign(shift_a, shift_b);
            end
        end
    end
`else
    assign decayed = shift_a;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StLoad;
            StLoad:  state_d = StCalc;
            StCalc:  state_d = StEmit;
            StEmit:  if (bus.out_ready) state_d = last_addr ? StDone : StLoad;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q     <= '0;
            cur_pot_q  <= '0;
            cur_rate_q <= '0;
            result_q   <= '0;
        end else begin
            if (state_q == StLoad) begin
                cur_pot_q  <= pot_q[addr_q];
                cur_rate_q <= rate_q[addr_q];
            end
            if (state_q == StCalc) begin
                result_q <= decayed;
            end
            if (emit_fire && !last_addr) begin
                addr_q <= addr_q + 1'b1;
            end
            if (state_q == StDone) begin
                addr_q <= '0;
            end
        end
    end

    // Per-neuron storage. In idle, a later upd write overrides a cfg write to
    // the same neuron while the cfg rate still lands.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_q[i]  <= INIT_POTENTIAL;
                rate_q[i] <= RATE_X1;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (state_q == StIdle) begin
                    if (bus.cfg_valid && bus.cfg_addr == ADDR_W'(i)) begin
                        pot_q[i]  <= bus.cfg_potential;
                        rate_q[i] <= bus.cfg_rate;
                    end
                    if (bus.upd_valid && bus.upd_addr == ADDR_W'(i)) begin
                        pot_q[i] <= bus.upd_potential;
                    end
                end else if (emit_fire && addr_q == ADDR_W'(i)) begin
                    pot_q[i] <= result_q;
                end
            end
        end
    end

    assign bus.out_valid     = (state_q == StEmit);
    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = (state_q == StDone);
    assign bus.out_addr      = addr_q;
    assign bus.out_potential = result_q;

endmodule

// File: tb/tb_potential_decay_unit.sv
// Self-checking bench for potential_decay_unit: directed steps with a
// scoreboard of expected (addr, potential) pairs filled at each start pulse.
module tb_potential_decay_unit;

    localparam int          N    = 32;
    localparam int          AW   = 5;
    localparam logic [31:0] INIT = 32'h41DED852;
`ifdef DECAY_THREEQ_EN
    localparam logic [31:0] THREEQ_EXP = 32'h40400000;
`else
    localparam logic [31:0] THREEQ_EXP = 32'h40800000;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   pot;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   el;
    bit   done_seen = 1'b0;
    bit   hit;
    exp_t sb[$];
    logic [31:0] model_pot [N];
    logic [3:0]  model_rate [N];
    logic [31:0] got [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    potential_decay_unit_if #(.ADDR_W(AW)) bus ();

    potential_decay_unit #(
        .NUM_NEURONS    (N),
        .ADDR_W         (AW),
        .INIT_POTENTIAL (INIT)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] shr(input logic [31:0] x, input int k);
        int e;
        e = int'(x[30:23]);
        if (k == 0 || e == 0 || e == 255) return x;
        if (e <= k) return {x[31], 31'b0};
        return {x[31], 8'(e - k), x[22:0]};
    endfunction

    // 0.75*x = 3*mant scaled by 2^-2, renormalised, truncated.
    function automatic logic [31:0] three_q(input logic [31:0] x);
        int          e;
        logic [25:0] p;
        e = int'(x[30:23]);
        if (e == 0 || e == 255) return x;
        if (e <= 2) return shr(x, 1);
        p = 26'({1'b1, x[22:0]}) * 26'd3;
        if (p[25]) return {x[31], 8'(e), p[24:2]};
        return {x[31], 8'(e - 1), p[23:1]};
    endfunction

    function automatic logic [31:0] model_decay(input logic [31:0] x, input logic [3:0] r);
        case (r)
            4'b0010: return shr(x, 1);
            4'b0100: return shr(x, 2);
            4'b1000: return shr(x, 3);
`ifdef DECAY_THREEQ_EN
            4'b0011: return three_q(x);
`endif
            default: return x;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < N; i++) begin
            model_pot[i]  = INIT;
            model_rate[i] = 4'b0001;
        end
    endtask

    task automatic cfg(input int a, input logic [31:0] p, input logic [3:0] r);
        bus.cfg_valid     = 1'b1;
        bus.cfg_addr      = AW'(a);
        bus.cfg_potential = p;
        bus.cfg_rate      = r;
        tick();
        bus.cfg_valid = 1'b0;
        model_pot[a]  = p;
        model_rate[a] = r;
    endtask

    task automatic queue_sweep;
        logic [31:0] d;
        for (int i = 0; i < N; i++) begin
            d = model_decay(model_pot[i], model_rate[i]);
            sb.push_back('{addr: AW'(i), pot: d});
            model_pot[i] = d;
        end
    endtask

    // Elapsed counts cycles from the start cycle to the done cycle (-1 on timeout).
    task automatic run_sweep(input int stall_addr, input int stalls, input bit poke,
                             output int elapsed);
        int          t0;
        int          left;
        logic [31:0] held_pot;
        logic [31:0] held_addr;
        queue_sweep();
        bus.start = 1'b1;
        t0 = cyc;
        tick();
        bus.start = 1'b0;
        elapsed = -1;
        left = stalls;
        held_pot = '0;
        held_addr = '0;
        bus.cfg_addr = '0;
        bus.cfg_potential = '0;
        bus.cfg_rate = 4'b1000;
        bus.upd_addr = AW'(1);
        bus.upd_potential = '0;
        for (int n = 0; n < 4000; n++) begin
            bus.start     = poke && (n == 4);
            bus.cfg_valid = poke && (n == 4);
            bus.upd_valid = poke && (n == 4);
            if (bus.out_valid && int'(bus.out_addr) == stall_addr && left > 0) begin
                if (left == stalls) begin
                    held_addr = 32'(bus.out_addr);
                    held_pot  = bus.out_potential;
                end else begin
                    chk("stall_addr_held", 32'(bus.out_addr), held_addr);
                    chk("stall_pot_held", bus.out_potential, held_pot);
                end
                bus.out_ready = 1'b0;
                left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.done) begin
                elapsed = cyc - t0;
                break;
            end
            tick();
        end
        bus.start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.upd_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        tick();
        tick();
        chk("idle_after_done", 32'(bus.busy), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.done) done_seen = 1'b1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_out observed=%0d expected=none", bus.out_addr);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_addr", 32'(bus.out_addr), 32'(e.addr));
                chk("out_potential", bus.out_potential, e.pot);
                got[bus.out_addr] = bus.out_potential;
            end
        end
    end

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_potential = '0;
        bus.cfg_rate = '0;
        bus.upd_valid = 1'b0;
        bus.upd_addr = '0;
        bus.upd_potential = '0;
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_out_addr", 32'(bus.out_addr), 32'd0);
        chk("rst_out_potential", bus.out_potential, 32'd0);

        // Sweep A: untouched neurons emit INIT_POTENTIAL, done at 3N+1
        run_sweep(-1, 0, 1'b0, el);
        chk("a_done_cycle", 32'(el), 32'(3 * N + 1));
        chk("a_first", got[0], INIT);
        chk("a_last", got[N-1], INIT);

        // Rates, x0.75, underflow, Inf, and cfg/upd collision
        cfg(1, 32'h40800000, 4'b0010);
        cfg(2, 32'h40800000, 4'b1000);
        cfg(3, 32'hC0800000, 4'b0100);
        cfg(5, 32'h40800000, 4'b0011);
        cfg(6, 32'h00800000, 4'b0100);
        cfg(7, 32'h80800000, 4'b1000);
        cfg(8, 32'h7F800000, 4'b1000);
        bus.upd_valid = 1'b1;
        bus.upd_addr = AW'(9);
        bus.upd_potential = 32'h40800000;
        cfg(9, 32'h11111111, 4'b0010);
        bus.upd_valid = 1'b0;
        model_pot[9] = 32'h40800000;

        // Sweep B: second start, cfg and upd while busy are dropped
        run_sweep(-1, 0, 1'b1, el);
        chk("b_done_cycle", 32'(el), 32'(3 * N + 1));
        chk("b_div2", got[1], 32'h40000000);
        chk("b_div8", got[2], 32'h3F000000);
        chk("b_div4_neg", got[3], 32'hBF800000);
        chk("b_threeq", got[5], THREEQ_EXP);
        chk("b_underflow_pos", got[6], 32'h00000000);
        chk("b_underflow_neg", got[7], 32'h80000000);
        chk("b_inf_pass", got[8], 32'h7F800000);
        chk("b_upd_wins", got[9], 32'h40000000);

        // Sweep C: 5-cycle stall at address 2 delays done by exactly 5
        run_sweep(2, 5, 1'b0, el);
        chk("c_done_cycle", 32'(el), 32'(3 * N + 6));
        chk("c_busy_cfg_dropped", got[0], INIT);
        chk("c_busy_upd_dropped", got[1], 32'h3F800000);

        // Sweep D: reset while address 4 is being emitted
        queue_sweep();
        done_seen = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (bus.out_valid && bus.out_addr == AW'(4)) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("d_reached_addr4", 32'(hit), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("d_rst_busy", 32'(bus.busy), 32'd0);
        chk("d_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("d_rst_done", 32'(bus.done), 32'd0);
        chk("d_rst_out_potential", bus.out_potential, 32'd0);
        tick();
        rst = 1'b0;
        sb.delete();
        model_reset();
        repeat (4) tick();
        chk("d_no_done", 32'(done_seen), 32'd0);

        // Sweep E: every neuron back at INIT_POTENTIAL with rate x1
        run_sweep(-1, 0, 1'b0, el);
        chk("e_done_cycle", 32'(el), 32'(3 * N + 1));
        chk("e_addr0", got[0], INIT);
        chk("e_addr3", got[3], INIT);
        chk("e_addr9", got[9], INIT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/potential_decay_unit.md
POTENTIAL_DECAY_UNIT -- requirements
Module: potential_decay_unit

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 32: neurons held and swept per timestep (range 2..1024).
REQ-002 SHALL have parameter ADDR_W, default $clog2(NUM_NEURONS): neuron address width.
REQ-003 SHALL have parameter INIT_POTENTIAL, default 32'h41DED852: FP32 potential loaded into every neuron at reset.
REQ-004 SHALL have ports (one clock; reset is asynchronous and active-high):
CLK  input  1  sole clock, rising edge
RST  input  1  asynchronous, active-high reset
cfg_valid  input  1  configuration write strobe
cfg_addr  input  ADDR_W  neuron to configure
cfg_potential  input  32  FP32 potential to load
cfg_rate  input  4  decay-rate code
upd_valid  input  1  new potential from the potential adder
upd_addr  input  ADDR_W  neuron being updated
upd_potential  input  32  FP32 value written when upd_valid is accepted
start  input  1  timestep pulse; begins one decay sweep
out_ready  input  1  downstream accepts out_* this cycle
out_valid  output  1  out_addr/out_potential valid
out_addr  output  ADDR_W  neuron being emitted
out_potential  output  32  decayed FP32 potential
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at sweep end

Function
REQ-005 SHALL store, per neuron, a 32-bit FP32 potential and a 4-bit rate code, both in registers.
REQ-006 SHALL apply rate codes as follows: 0001 = x1, 0010 = x/2, 0100 = x/4, 1000 = x/8, 0011 = x/2 + x/4 (x0.75), any other code = x1.
REQ-007 SHALL implement the x/2^k codes by subtracting k from the exponent while keeping sign and mantissa unchanged.
REQ-008 SHALL output signed zero ({sign,31'b0}) whenever exponent <= k; the exponent SHALL never wrap.
REQ-009 SHALL pass zero, denormal (exponent 0) and Inf/NaN (exponent 255) inputs through unchanged.
REQ-010 SHALL run an FSM with states IDLE, LOAD, CALC, EMIT and DONE.
REQ-011 SHALL move IDLE->LOAD when start is sampled high in IDLE, with the address counter at 0.
REQ-012 SHALL, in LOAD, register the potential and rate of the current address, then move LOAD->CALC.
REQ-013 SHALL, in CALC, register the decayed result, then move CALC->EMIT.
REQ-014 SHALL hold out_valid high in EMIT with out_addr and out_potential stable until out_ready is high.
REQ-015 SHALL, on the EMIT handshake, write the decayed value back to the neuron; it then moves to LOAD at the next address, or to DONE after the last address.
REQ-016 SHALL, in DONE, assert done for exactly one cycle and return to IDLE.
REQ-017 SHALL drive busy high in every state except IDLE.
REQ-018 SHALL, with out_ready held high, assert done in cycle 3*NUM_NEURONS+1 after the cycle in which start was sampled.
REQ-019 SHALL ignore start while busy is high.
REQ-020 SHALL accept cfg_valid and upd_valid only in IDLE and silently drop them otherwise.
REQ-021 SHALL let upd win when cfg_valid and upd_valid hit the same address in the same cycle; cfg_rate is still written.
REQ-022 SHALL emit neurons in ascending address order, starting at 0 and ending at NUM_NEURONS-1, with no wrap-around.

Reset
REQ-023 SHALL, on RST, immediately return to IDLE, regardless of clock.
REQ-024 SHALL, on RST, set every potential to INIT_POTENTIAL, every rate to 0001, and the address counter to 0.
REQ-025 SHALL, on RST, drive out_valid, busy and done to 0 and out_addr and out_potential to 0.
REQ-026 SHALL, on RST asserted mid-sweep, abandon the sweep, discard any partial write-back, and issue no done pulse.

Configuration
REQ-027 SHALL compile in the 0011 (x0.75) mode only when DECAY_THREEQ_EN is defined; the FP32 adder is then instantiated and the sum is registered in CALC with unchanged latency.
REQ-028 SHALL, without DECAY_THREEQ_EN, instantiate no adder and treat code 0011 as x1.

Structure
REQ-029 SHALL take the rate-code constants, the FSM state enum and the FP32 field widths/positions from shared package snn_decay_pkg.
REQ-030 SHALL place the combinational exponent shift with underflow clamp in sub-module potential_decay_shift, instantiated twice under DECAY_THREEQ_EN (for k=1 and k=2) and once otherwise.

Verification
REQ-031 SHALL check reset: after RST, out_valid = busy = done = 0, and a sweep with rate 0001 emits 0x41DED852 for every address.
REQ-032 SHALL check rates: cfg addr1 = 0x40800000/0010, addr2 = 0x40800000/1000, addr3 = 0xC0800000/0100, then start -> out_potential 0x40000000, 0x3F000000, 0xBF800000 at addr 1, 2, 3; done at cycle 3N+1.
REQ-033 SHALL check x0.75: 0x40800000 with rate 0011 -> 0x40400000 with DECAY_THREEQ_EN, and 0x40800000 without it.
REQ-034 SHALL check underflow: 0x00800000/0100 -> 0x00000000 and 0x80800000/1000 -> 0x80000000; 0x7F800000 passes through unchanged.
REQ-035 SHALL check backpressure: out_ready low for 5 cycles in EMIT -> out_* held stable and done delayed exactly 5 cycles; second start while busy ignored.
REQ-036 SHALL check reset mid-sweep: RST at address 4 -> IDLE, no done, all potentials = INIT_POTENTIAL.
